// File: rtl/instruction_serializer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_serializer
// Description : Buffers 16-bit instruction words in a 2-entry FIFO and
//               streams each word as two bytes (order set by HIGH_FIRST)
//               toward an instruction register, honouring a downstream
//               Hold stall and pulsing Done after each completed word.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_serializer #(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] word_i,
   input  logic        word_valid_i,
   output logic        word_ready_o,
   input  logic        hold_i,
   output logic [7:0]  i_o,
   output logic        lh_o,
   output logic        write_o,
   output logic        done_o,
   output logic [1:0]  pending_o
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SEND_FIRST  = 2'd1,
      SEND_SECOND = 2'd2
   } state_e;

   localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

   state_e      state_q, state_d;
   logic [15:0] mem_q [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  count_q, count_d;
   logic [7:0]  i_q, i_d;
   logic        lh_q, lh_d;
   logic        done_q;

   logic        w_push;
   logic        w_pop;
   logic [15:0] w_head_next;

   // Handshake, occupancy, next FIFO head and next state / byte selection.
   always_comb begin
      // Acceptance depends only on registered occupancy, so a same-cycle
      // pop never opens the door to a third word.
      w_push  = word_valid_i && (count_q != c_FIFO_DEPTH);
      w_pop   = (state_q == SEND_SECOND) && !hold_i;
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};

      // Word that will sit at the FIFO head after this edge; a word pushed
      // into an empty (or emptying) FIFO is forwarded straight from word_i.
      if (w_pop) begin
         w_head_next = (count_q == c_FIFO_DEPTH) ? mem_q[~rd_ptr_q] : word_i;
      end else begin
         w_head_next = (count_q == 2'd0) ? word_i : mem_q[rd_ptr_q];
      end

      state_d = state_q;
      case (state_q)
         IDLE:        if (w_push || (count_q != 2'd0)) state_d = SEND_FIRST;
         SEND_FIRST:  if (!hold_i) state_d = SEND_SECOND;
         SEND_SECOND: if (!hold_i) state_d = (count_d != 2'd0) ? SEND_FIRST : IDLE;
         default:     state_d = IDLE;
      endcase

      i_d  = 8'h00;
      lh_d = 1'b0;
      if (state_d == SEND_FIRST) begin
         lh_d = HIGH_FIRST;
         i_d  = lh_d ? w_head_next[15:8] : w_head_next[7:0];
      end else if (state_d == SEND_SECOND) begin
         lh_d = !HIGH_FIRST;
         i_d  = lh_d ? w_head_next[15:8] : w_head_next[7:0];
      end
   end

   // FIFO storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= word_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_push) wr_ptr_q <= ~wr_ptr_q;
         if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   // Serializer FSM with registered byte, half-select and Done outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         i_q     <= 8'h00;
         lh_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         lh_q    <= lh_d;
         done_q  <= w_pop;
      end
   end

   assign word_ready_o = (count_q != c_FIFO_DEPTH);
   assign pending_o    = count_q;
   assign i_o          = i_q;
   assign lh_o         = lh_q;
   assign done_o       = done_q;
   assign write_o      = (state_q != IDLE) && !hold_i;

endmodule
`default_nettype wire

// File: doc/instruction_serializer.md
INSTRUCTION_SERIALIZER -- requirements
Module: instruction_serializer

Interface
REQ-001 The block SHALL have parameter HIGH_FIRST, default 0. It selects byte order: 0 = low byte [7:0] first, 1 = high byte [15:8] first.
REQ-002 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 WordIn  input  16  instruction word to transmit.
REQ-005 WordValid  input  1  WordIn is valid this cycle.
REQ-006 WordReady  output  1  block can accept a word this cycle.
REQ-007 Hold  input  1  downstream stall; no byte is transferred in a cycle where Hold=1.
REQ-008 I  output  8  byte bus toward the instruction register.
REQ-009 LH  output  1  half select: 1 = byte is [15:8], 0 = byte is [7:0].
REQ-010 Write  output  1  byte on I/LH is transferred at the next rising edge.
REQ-011 Done  output  1  one-cycle pulse when a full word has been transferred.
REQ-012 Pending  output  2  words held, 0..2, including the word in transmission.

Function
REQ-013 Words SHALL be buffered in a 2-entry FIFO, with Pending equal to its occupancy register.
REQ-014 WordReady SHALL equal (Pending < 2), taken from registered state only.
- A pop in the same cycle SHALL NOT raise WordReady.
REQ-015 A word SHALL be accepted at a rising edge where WordValid=1 and WordReady=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND_FIRST, SEND_SECOND.
REQ-017 IDLE -> SEND_FIRST at an edge where a word is accepted or Pending>0.
- The first byte SHALL be presented in the cycle immediately after the acceptance edge.
REQ-018 In SEND_FIRST and SEND_SECOND, outputs SHALL be driven as follows:
- Write = ~Hold.
- I and LH are taken from the FIFO head.
REQ-019 In SEND_FIRST, I and LH SHALL carry the first byte:
- HIGH_FIRST=0: I=[7:0], LH=0.
- HIGH_FIRST=1: I=[15:8], LH=1.
REQ-020 In SEND_SECOND, I and LH SHALL carry the other half, with the complementary LH.
REQ-021 SEND_FIRST -> SEND_SECOND only at an edge with Hold=0.
- With Hold=1, state, I and LH SHALL hold their values.
REQ-022 At a SEND_SECOND edge with Hold=0, the head word SHALL be popped, and the next state SHALL be:
- SEND_FIRST if post-pop occupancy, including a same-edge push, is >=1 (no bubble; 1 word per 2 cycles).
- IDLE otherwise.
REQ-023 Done SHALL be registered and high for exactly the cycle after each pop edge.
REQ-024 A simultaneous push and pop SHALL leave Pending unchanged and preserve FIFO order.
REQ-025 In IDLE, outputs SHALL be I=8'h00, LH=0, Write=0.
- Hold SHALL be ignored in IDLE.
REQ-026 WordIn SHALL be sampled only at acceptance; later changes to WordIn SHALL NOT affect bytes already queued.

Reset
REQ-027 Reset=1 SHALL immediately force the following, independent of Clock:
- State = IDLE; FIFO empty.
- Pending=0, WordReady=1, Write=0, LH=0, I=8'h00, Done=0.
REQ-028 On reset mid-word, the partially sent word SHALL be discarded.
- No further byte and no Done SHALL be produced for it.
REQ-029 The first acceptance SHALL be possible at the first rising edge after Reset deasserts.

Verification
REQ-030 HIGH_FIRST=0, Hold=0, single word 16'hA55A; the bench SHALL check:
- Cycle+1: I=5A, LH=0, Write=1.
- Cycle+2: I=A5, LH=1, Write=1.
- Cycle+3: Done=1, Write=0, Pending=0.
REQ-031 HIGH_FIRST=1, word 16'hBEEF; the bench SHALL check:
- Byte 1: I=BE, LH=1.
- Byte 2: I=EF, LH=0.
- Then Done.
REQ-032 Words 1234, 5678, 9ABC with WordValid held high; the bench SHALL check:
- WordReady=0 while Pending=2.
- Bytes 34,12,78,56,BC,9A with Write high on consecutive cycles.
- Three Done pulses, two cycles apart.
REQ-033 Hold=1 for 3 cycles during SEND_SECOND of 16'h00FF; the bench SHALL check:
- Write=0 while held, with I=00 and LH=1 stable.
- Transfer completes after release; Done is delayed by 3 cycles.
REQ-034 Reset pulsed asynchronously right after the first byte of 16'hC3D2; the bench SHALL check:
- Outputs are zero before the next edge.
- Pending=0.
- No byte D2/C3 appears afterward and no Done.
REQ-035 Pending=2 with a pop edge and WordValid=1 in the same cycle; the bench SHALL check:
- The word is not accepted.
- Pending=1 after the edge.
- The word is accepted at the following edge.
